// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state type and counter widths for the PLL frequency sweep sequencer
//   DEF_* are the production defaults; the widths are sized for them so any
//   smaller override of the top-level parameters fits the same counters.
package sweep_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RDY, DWELL, DONE, ERROR} state_t;
  localparam int DEF_DWELL_CYCLES = 50_000_000;
  localparam int DEF_WD_CYCLES = 1_000_000;
  localparam int STEP_W = 9;
  localparam int DWELL_W = $clog2(DEF_DWELL_CYCLES + 1);
  localparam int WD_W = $clog2(DEF_WD_CYCLES + 1);
endpackage

// File: rtl/sweep_if.sv
// sweep_if: step handshake between the sweep initiator and the PLL reconfig block
//   next_frequency : initiator -> PLL, step request held until acknowledged
//   freq_ready     : PLL -> initiator, high while the output clock is stable
interface sweep_if;
  logic next_frequency;
  logic freq_ready;
  modport master (output next_frequency, input freq_ready);
  modport slave (input next_frequency, output freq_ready);
endinterface

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: loadable down-counter that parks at zero
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (wins over en)
//   en         : decrement by one while nonzero
//   zero       : counter is zero
module sweep_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: automatic PLL frequency sweep (request step, wait ready, dwell, repeat)
//   CLK_50, reset_n : 50 MHz clock, asynchronous active-low reset
//   start, abort    : level inputs; start rise begins a sweep, abort returns to IDLE
//   pll             : sweep_if.master (next_frequency out, freq_ready in)
//   busy, dwell_tick, step_count, done, error : registered status outputs
//   Build option SWEEP_WATCHDOG_EN: per-phase handshake watchdog with an ERROR exit.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int NUM_STEPS = 512
`ifdef SWEEP_WATCHDOG_EN
  ,
  parameter int WD_CYCLES = DEF_WD_CYCLES
`endif
) (
  input  logic              CLK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  sweep_if.master           pll,
  output logic              busy,
  output logic              dwell_tick,
  output logic [STEP_W-1:0] step_count,
  output logic              done,
  output logic              error
);
  state_t state;
  logic start_q, start_rise, nf, dwell_zero, wd_exp;
  logic [STEP_W:0] step_nxt;
  assign start_rise = start & ~start_q;
  assign step_nxt = {1'b0, step_count} + 1'b1;
  assign pll.next_frequency = nf;
  // Held loaded outside DWELL, so every entry (including after a lock loss) starts a full dwell.
  sweep_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk(CLK_50), .rst_n(reset_n), .load(state != DWELL), .en(state == DWELL),
    .load_val(DWELL_W'(DWELL_CYCLES - 1)), .zero(dwell_zero)
  );
`ifdef SWEEP_WATCHDOG_EN
  logic wd_zero;
  // Reloaded outside the handshake and on the REQ->WAIT_RDY edge, so each phase gets WD_CYCLES.
  sweep_dwell_timer #(.W(WD_W)) u_wd (
    .clk(CLK_50), .rst_n(reset_n),
    .load(!(state == REQ || state == WAIT_RDY) || (state == REQ && !pll.freq_ready)),
    .en(1'b1), .load_val(WD_W'(WD_CYCLES - 1)), .zero(wd_zero)
  );
  assign wd_exp = wd_zero;
`else
  assign wd_exp = 1'b0;
`endif
  always_ff @(posedge CLK_50 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      nf <= 1'b0;
      busy <= 1'b0;
      dwell_tick <= 1'b0;
      step_count <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      start_q <= start;
      dwell_tick <= 1'b0;
      if (abort) begin
        state <= IDLE;
        nf <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
        error <= 1'b0;
      end else case (state)
        REQ, WAIT_RDY:
          if (wd_exp) begin
            state <= ERROR;
            nf <= 1'b0;
            busy <= 1'b0;
            error <= 1'b1;
          end else if (state == REQ) begin
            // PLL dropping ready is the acknowledge; request falls on that same edge.
            nf <= pll.freq_ready;
            if (!pll.freq_ready) state <= WAIT_RDY;
          end else if (pll.freq_ready) state <= DWELL;
        DWELL:
          if (!pll.freq_ready) state <= WAIT_RDY;
          else if (dwell_zero) begin
            dwell_tick <= 1'b1;
            step_count <= step_nxt[STEP_W-1:0];
            if (step_nxt == (STEP_W + 1)'(NUM_STEPS)) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else state <= REQ;
          end
        default:
          if (start_rise) begin
            state <= REQ;
            step_count <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: randomized scenario bench for sweep_sequencer with a behavioural PLL model
module tb_sweep_sequencer;
  localparam int DW = 10;
  localparam int NS = 4;
  logic CLK_50 = 0, reset_n = 0, start = 0, abort = 0;
  logic busy, dwell_tick, done, error;
  logic [8:0] step_count;
  sweep_if pif ();
  sweep_sequencer #(
    .DWELL_CYCLES(DW), .NUM_STEPS(NS)
`ifdef SWEEP_WATCHDOG_EN
    , .WD_CYCLES(50)
`endif
  ) dut (
    .CLK_50(CLK_50), .reset_n(reset_n), .start(start), .abort(abort), .pll(pif),
    .busy(busy), .dwell_tick(dwell_tick), .step_count(step_count), .done(done), .error(error)
  );
  always #10 CLK_50 = ~CLK_50;

  int total = 0, bad = 0, cyc = 0;
  int ret_delay = 20, fall_at = -1, rise_at = -1, drop_left = 0;
  bit never_drop = 0, fr_model = 1, nf_prev = 0;
  int nf_rises[$], fr_rises[$], ticks[$], tick_steps[$];

  always @(posedge CLK_50) cyc++;

  // PLL model and event log: ready falls 3 cycles after a request rises, returns ret_delay later.
  // fr_rises holds the cycle whose rising edge first sees freq_ready high.
  always @(negedge CLK_50) begin
    logic fr_new;
    if (pif.next_frequency && !nf_prev) begin
      nf_rises.push_back(cyc);
      if (!never_drop) fall_at = cyc + 3;
    end
    nf_prev = pif.next_frequency;
    if (dwell_tick) begin
      ticks.push_back(cyc);
      tick_steps.push_back(int'(step_count));
    end
    if (cyc == fall_at) begin fr_model = 0; rise_at = cyc + ret_delay; fall_at = -1; end
    else if (cyc == rise_at) begin fr_model = 1; rise_at = -1; end
    fr_new = fr_model && drop_left == 0;
    if (drop_left > 0) drop_left--;
    if (fr_new && !pif.freq_ready) fr_rises.push_back(cyc + 1);
    pif.freq_ready = fr_new;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_50);
    #1;
  endtask

  task automatic clear_log;
    nf_rises.delete(); fr_rises.delete(); ticks.delete(); tick_steps.delete();
  endtask

  task automatic pulse_start(output int s);
    start = 1; s = cyc;
    step(1);
    start = 0;
  endtask

  task automatic stop_and_settle;
    abort = 1; step(1); abort = 0; step(40);
  endtask

  task automatic test_reset;
    reset_n = 0; step(3);
    total++; if ({busy, pif.next_frequency, dwell_tick, done, error, step_count} !== 14'd0) begin bad++; $display("FAIL reset_held: got %b want all 0", {busy, pif.next_frequency, dwell_tick, done, error, step_count}); end
    reset_n = 1; step(3);
    total++; if ({busy, pif.next_frequency, dwell_tick, done, error, step_count} !== 14'd0) begin bad++; $display("FAIL reset_released: got %b want all 0", {busy, pif.next_frequency, dwell_tick, done, error, step_count}); end
  endtask

  task automatic test_sweep;
    int s, p;
    clear_log(); ret_delay = 20; p = 5 + ret_delay + DW;
    step($urandom_range(1, 6));
    pulse_start(s);
    for (int i = 0; i < 1000 && !done; i++) step(1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sweep_done: got %b want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sweep_busy: got %b want 0", busy); end
    total++; if (step_count !== 9'(NS)) begin bad++; $display("FAIL sweep_steps: got %0d want %0d", step_count, NS); end
    total++; if (nf_rises.size() != NS) begin bad++; $display("FAIL sweep_requests: got %0d want %0d", nf_rises.size(), NS); end
    total++; if (ticks.size() != NS) begin bad++; $display("FAIL sweep_ticks: got %0d want %0d", ticks.size(), NS); end
    if (nf_rises.size() > 0) begin
      total++; if (nf_rises[0] != s + 2) begin bad++; $display("FAIL start_latency: got %0d want %0d", nf_rises[0] - s, 2); end
    end
    for (int i = 0; i < ticks.size(); i++) begin
      total++; if (ticks[i] != s + 6 + ret_delay + DW + p * i) begin bad++; $display("FAIL tick_time[%0d]: got %0d want %0d", i, ticks[i], s + 6 + ret_delay + DW + p * i); end
      total++; if (tick_steps[i] != i + 1) begin bad++; $display("FAIL tick_step[%0d]: got %0d want %0d", i, tick_steps[i], i + 1); end
      if (i < fr_rises.size()) begin
        total++; if (ticks[i] - fr_rises[i] != DW) begin bad++; $display("FAIL dwell_len[%0d]: got %0d want %0d", i, ticks[i] - fr_rises[i], DW); end
      end
    end
    step(10);
  endtask

  task automatic test_abort;
    int s, w, n;
    clear_log(); ret_delay = $urandom_range(15, 25);
    pulse_start(s);
    for (int i = 0; i < 500 && fr_rises.size() < 2; i++) step(1);
    total++; if (fr_rises.size() < 2) begin bad++; $display("FAIL abort_reach_dwell2: got %0d want 2", fr_rises.size()); end
    w = fr_rises.size() >= 2 ? fr_rises[1] : cyc;
    step($urandom_range(1, 8));
    abort = 1; step(1);
    total++; if ({busy, pif.next_frequency, done} !== 3'b000) begin bad++; $display("FAIL abort_outputs: got %b want 000 at dwell offset %0d", {busy, pif.next_frequency, done}, cyc - w); end
    total++; if (step_count !== 9'd1) begin bad++; $display("FAIL abort_steps: got %0d want 1", step_count); end
    abort = 0; n = nf_rises.size();
    step(40);
    total++; if (nf_rises.size() != n || busy !== 1'b0) begin bad++; $display("FAIL abort_quiet: got %0d requests busy=%b want %0d busy=0", nf_rises.size(), busy, n); end
    abort = 1; start = 1; step(2);
    abort = 0; step(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start: got busy=%b want 0", busy); end
    start = 0; step(1);
    pulse_start(s);
    total++; if (busy !== 1'b1 || step_count !== 9'd0) begin bad++; $display("FAIL restart_clear: got busy=%b steps=%0d want busy=1 steps=0", busy, step_count); end
    for (int i = 0; i < 1000 && !done; i++) step(1);
    total++; if (done !== 1'b1 || step_count !== 9'(NS)) begin bad++; $display("FAIL restart_done: got done=%b steps=%0d want 1 %0d", done, step_count, NS); end
    step(10);
  endtask

  task automatic test_relock;
    int s, d0;
    clear_log(); ret_delay = 20;
    pulse_start(s);
    for (int i = 0; i < 500 && fr_rises.size() < 1; i++) step(1);
    step($urandom_range(1, 6));
    d0 = cyc; drop_left = 5;
    for (int i = 0; i < 100 && ticks.size() < 1; i++) step(1);
    total++; if (ticks.size() < 1) begin bad++; $display("FAIL relock_tick: got none want 1"); end
    else begin
      total++; if (ticks[0] != d0 + 7 + DW) begin bad++; $display("FAIL relock_tick_time: got %0d want %0d", ticks[0], d0 + 7 + DW); end
      total++; if (tick_steps[0] != 1) begin bad++; $display("FAIL relock_step: got %0d want 1", tick_steps[0]); end
    end
    stop_and_settle();
  endtask

  task automatic test_hold_start;
    int s;
    clear_log(); ret_delay = $urandom_range(15, 25);
    start = 1; s = cyc;
    for (int i = 0; i < 1000 && !done; i++) step(1);
    step(30);
    total++; if (done !== 1'b1 || busy !== 1'b0 || nf_rises.size() != NS) begin bad++; $display("FAIL hold_no_resweep: got done=%b busy=%b req=%0d want 1 0 %0d", done, busy, nf_rises.size(), NS); end
    if (nf_rises.size() > 0) begin
      total++; if (nf_rises[0] != s + 2) begin bad++; $display("FAIL hold_latency: got %0d want 2", nf_rises[0] - s); end
    end
    start = 0; step(1);
    start = 1; step(1);
    total++; if (busy !== 1'b1 || done !== 1'b0 || step_count !== 9'd0) begin bad++; $display("FAIL hold_restart: got busy=%b done=%b steps=%0d want 1 0 0", busy, done, step_count); end
    step(1);
    total++; if (pif.next_frequency !== 1'b1) begin bad++; $display("FAIL hold_restart_req: got %b want 1", pif.next_frequency); end
    start = 0;
    stop_and_settle();
  endtask

  task automatic test_watchdog;
    int s;
    clear_log(); never_drop = 1;
    pulse_start(s);
`ifdef SWEEP_WATCHDOG_EN
    step(s + 50 - cyc);
    total++; if ({error, pif.next_frequency, busy} !== 3'b011) begin bad++; $display("FAIL wd_before: got %b want 011", {error, pif.next_frequency, busy}); end
    step(1);
    total++; if ({error, pif.next_frequency, busy, done} !== 4'b1000) begin bad++; $display("FAIL wd_error: got %b want 1000", {error, pif.next_frequency, busy, done}); end
    step(5);
    pulse_start(s);
    total++; if (busy !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL wd_recover: got busy=%b error=%b want 1 0", busy, error); end
    step(1);
    total++; if (pif.next_frequency !== 1'b1) begin bad++; $display("FAIL wd_recover_req: got %b want 1", pif.next_frequency); end
`else
    step(200);
    total++; if ({error, pif.next_frequency, busy} !== 3'b011) begin bad++; $display("FAIL nowd_wait: got %b want 011", {error, pif.next_frequency, busy}); end
`endif
    abort = 1; step(1); abort = 0;
    never_drop = 0; step(5);
  endtask

  task automatic test_async_reset;
    int s;
    clear_log(); ret_delay = 20;
    pulse_start(s);
    for (int i = 0; i < 500 && !(nf_rises.size() >= 2 && pif.next_frequency === 1'b0); i++) step(1);
    step(2);
    total++; if (busy !== 1'b1 || step_count !== 9'd1) begin bad++; $display("FAIL areset_pre: got busy=%b steps=%0d want 1 1", busy, step_count); end
    #5 reset_n = 0;
    #1;
    total++; if ({busy, pif.next_frequency, dwell_tick, done, error, step_count} !== 14'd0) begin bad++; $display("FAIL areset_immediate: got %b want all 0", {busy, pif.next_frequency, dwell_tick, done, error, step_count}); end
    step(2);
    reset_n = 1; step(40);
    total++; if ({busy, pif.next_frequency, done, step_count} !== 12'd0) begin bad++; $display("FAIL areset_idle: got %b want all 0", {busy, pif.next_frequency, done, step_count}); end
    pulse_start(s);
    step(1);
    total++; if (busy !== 1'b1 || pif.next_frequency !== 1'b1) begin bad++; $display("FAIL areset_restart: got busy=%b req=%b want 1 1", busy, pif.next_frequency); end
    stop_and_settle();
  endtask

  initial begin
    pif.freq_ready = 1;
    test_reset();
    test_sweep();
    test_abort();
    test_relock();
    test_hold_start();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
